mem_port_arbiter: RTL and testbench

Arbitrates a single shared single-port memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage), replacing the separate instruction and data memories. It sequences each access through a fixed-latency memory, returns the read data, and drives per-requester stall signals into the pipeline's stall/flush logic. One access is in flight at a time, with back-to-back issue.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_lat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbState_e;

    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [3:0] FETCH_BE = 4'hF;

    function automatic int latCountWidth(input int memLat);
        return $clog2(memLat + 1);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter tracking the cycles left until the memory returns data.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    localparam int CW = latCountWidth(MEM_LAT)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CW-1:0] countReg;

    // Load wins over decrement so a back-to-back grant restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= CW'(MEM_LAT);
        end else if (dec && (countReg != '0)) begin
            countReg <= countReg - CW'(1);
        end
    end

    assign zero = (countReg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports,
// one access in flight, with back-to-back issue and fetch/data alternation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    arbState_e   stateReg;
    arbState_e   stateNext;
    logic        lastOwnerReg;
    logic        ifValidReg;
    logic        dValidReg;
    logic [31:0] ifRdataReg;
    logic [31:0] dRdataReg;
    logic        memReqReg;
    logic        memWeReg;
    logic [31:0] memAddrReg;
    logic [31:0] memWdataReg;
    logic [3:0]  memBeReg;

    logic busy;
    logic done;
    logic grantEval;
    logic maskI;
    logic maskD;
    logic reqI;
    logic reqD;
    logic pickI;
    logic pickD;
    logic cntZero;

    mem_lat_counter #(
        .MEM_LAT(MEM_LAT)
    ) latCounter (
        .clk (clk),
        .rst (rst),
        .load(pickI || pickD),
        .dec (busy),
        .zero(cntZero)
    );

    // A requester keeps req high up to and including its valid cycle, so it is
    // masked both on its completing edge and while its valid pulse is out.
    always_comb begin
        busy      = (stateReg != IDLE);
        done      = busy && cntZero;
        grantEval = !busy || done;
        maskI     = (done && (stateReg == BUSY_I)) || (!busy && ifValidReg);
        maskD     = (done && (stateReg == BUSY_D)) || (!busy && dValidReg);
        reqI      = if_req && !maskI;
        reqD      = d_req && !maskD;
        pickD     = grantEval && reqD && !(reqI && (lastOwnerReg == OWN_D));
        pickI     = grantEval && reqI && !pickD;
        stateNext = stateReg;
        if (pickD) begin
            stateNext = BUSY_D;
        end else if (pickI) begin
            stateNext = BUSY_I;
        end else if (done) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            lastOwnerReg <= OWN_I;
            ifValidReg   <= 1'b0;
            dValidReg    <= 1'b0;
            ifRdataReg   <= '0;
            dRdataReg    <= '0;
            memReqReg    <= 1'b0;
            memWeReg     <= 1'b0;
            memAddrReg   <= '0;
            memWdataReg  <= '0;
            memBeReg     <= '0;
        end else begin
            stateReg   <= stateNext;
            memReqReg  <= pickI || pickD;
            ifValidReg <= done && (stateReg == BUSY_I);
            dValidReg  <= done && (stateReg == BUSY_D);
            if (done) begin
                if (stateReg == BUSY_I) begin
                    ifRdataReg   <= mem_rdata;
                    lastOwnerReg <= OWN_I;
                end else begin
                    // memWeReg still describes the completing access here.
                    dRdataReg    <= memWeReg ? 32'h0 : mem_rdata;
                    lastOwnerReg <= OWN_D;
                end
            end
            if (pickD) begin
                memWeReg    <= d_we;
                memAddrReg  <= d_addr;
                memWdataReg <= d_wdata;
                memBeReg    <= d_be;
            end else if (pickI) begin
                memWeReg    <= 1'b0;
                memAddrReg  <= if_addr;
                memWdataReg <= '0;
                memBeReg    <= FETCH_BE;
            end
        end
    end

    assign if_valid  = ifValidReg;
    assign if_rdata  = ifRdataReg;
    assign if_stall  = if_req & ~ifValidReg;
    assign d_valid   = dValidReg;
    assign d_rdata   = dRdataReg;
    assign d_stall   = d_req & ~dValidReg;
    assign mem_req   = memReqReg;
    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
    assign mem_be    = memBeReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance 0 runs with MEM_LAT=2, instance 1 with MEM_LAT=1.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    typedef struct {
        int          inst;
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq    [2];
    logic [31:0] ifAddr   [2];
    logic        ifValid  [2];
    logic [31:0] ifRdata  [2];
    logic        ifStall  [2];
    logic        dReq     [2];
    logic        dWe      [2];
    logic [31:0] dAddr    [2];
    logic [31:0] dWdata   [2];
    logic [3:0]  dBe      [2];
    logic        dValid   [2];
    logic [31:0] dRdata   [2];
    logic        dStall   [2];
    logic        memReq   [2];
    logic        memWe    [2];
    logic [31:0] memAddr  [2];
    logic [31:0] memWdata [2];
    logic [3:0]  memBe    [2];
    logic [31:0] memRdata [2];

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          respCyc [2] = '{-1, -1};
    logic [31:0] respData [2];
    exp_t        memQ[$];
    exp_t        ifQ[$];
    exp_t        dQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_port_arbiter #(
            .MEM_LAT(gi == 0 ? 2 : 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (ifReq[gi]),
            .if_addr  (ifAddr[gi]),
            .if_valid (ifValid[gi]),
            .if_rdata (ifRdata[gi]),
            .if_stall (ifStall[gi]),
            .d_req    (dReq[gi]),
            .d_we     (dWe[gi]),
            .d_addr   (dAddr[gi]),
            .d_wdata  (dWdata[gi]),
            .d_be     (dBe[gi]),
            .d_valid  (dValid[gi]),
            .d_rdata  (dRdata[gi]),
            .d_stall  (dStall[gi]),
            .mem_req  (memReq[gi]),
            .mem_we   (memWe[gi]),
            .mem_addr (memAddr[gi]),
            .mem_wdata(memWdata[gi]),
            .mem_be   (memBe[gi]),
            .mem_rdata(memRdata[gi])
        );
    end

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Memory contents as seen by the bench.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h40) return 32'h24020005;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] cycle=%0d actual=%h required=%h", name, k, cyc, act, exp);
        end
    endtask

    task automatic pushMem(input int k, input int c, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        e.inst = k; e.cyc = c; e.we = we; e.addr = addr; e.data = wdata; e.be = be;
        memQ.push_back(e);
    endtask

    task automatic pushRsp(input bit isData, input int k, input int c, input logic [31:0] data);
        exp_t e;
        e.inst = k; e.cyc = c; e.we = 1'b0; e.addr = '0; e.data = data; e.be = '0;
        if (isData) dQ.push_back(e);
        else ifQ.push_back(e);
    endtask

    // Memory model: answers exactly lat() cycles after mem_req, junk otherwise.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            memRdata[k] <= (cyc == respCyc[k]) ? respData[k] : 32'hBAD0BAD0;
            if (memReq[k]) begin
                respCyc[k]  <= cyc + lat(k);
                respData[k] <= memWord(memAddr[k]);
            end
        end
    end

    // Monitor: pops the scoreboard whenever a DUT presents mem_req or a valid.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (memReq[k]) begin
                if (memQ.size() == 0) begin
                    chk("mem_req_unexpected", k, 32'(memReq[k]), 32'h0);
                end else begin
                    e = memQ.pop_front();
                    chk("mem_inst", k, k, e.inst);
                    chk("mem_cycle", k, cyc, e.cyc);
                    chk("mem_we", k, 32'(memWe[k]), 32'(e.we));
                    chk("mem_addr", k, memAddr[k], e.addr);
                    chk("mem_be", k, 32'(memBe[k]), 32'(e.be));
                    if (e.we) chk("mem_wdata", k, memWdata[k], e.data);
                end
            end
            if (ifValid[k]) begin
                if (ifQ.size() == 0) begin
                    chk("if_valid_unexpected", k, 32'(ifValid[k]), 32'h0);
                end else begin
                    e = ifQ.pop_front();
                    chk("if_inst", k, k, e.inst);
                    chk("if_cycle", k, cyc, e.cyc);
                    chk("if_rdata", k, ifRdata[k], e.data);
                end
            end
            if (dValid[k]) begin
                if (dQ.size() == 0) begin
                    chk("d_valid_unexpected", k, 32'(dValid[k]), 32'h0);
                end else begin
                    e = dQ.pop_front();
                    chk("d_inst", k, k, e.inst);
                    chk("d_cycle", k, cyc, e.cyc);
                    chk("d_rdata", k, dRdata[k], e.data);
                end
            end
        end
        while (memQ.size() > 0 && memQ[0].cyc < cyc) begin
            e = memQ.pop_front();
            chk("mem_req_missing", e.inst, 32'h0, 32'h1);
        end
        while (ifQ.size() > 0 && ifQ[0].cyc < cyc) begin
            e = ifQ.pop_front();
            chk("if_valid_missing", e.inst, 32'h0, 32'h1);
        end
        while (dQ.size() > 0 && dQ[0].cyc < cyc) begin
            e = dQ.pop_front();
            chk("d_valid_missing", e.inst, 32'h0, 32'h1);
        end
    end

    // Requesters: raise req at the current cycle, hold it through the valid
    // cycle, then either drop it or leave it up for the caller's next access.
    task automatic fetchOp(input int k, input logic [31:0] addr, input bit keep, output int stallCyc);
        ifReq[k] = 1'b1;
        ifAddr[k] = addr;
        stallCyc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ifStall[k]) stallCyc++;
            if (ifValid[k]) break;
        end
        if (!ifValid[k]) chk("if_valid_timeout", k, 32'h0, 32'h1);
        @(posedge clk); #1;
        if (!keep) ifReq[k] = 1'b0;
    endtask

    task automatic dataOp(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit keep, output int stallCyc);
        dReq[k] = 1'b1;
        dWe[k] = we;
        dAddr[k] = addr;
        dWdata[k] = wdata;
        dBe[k] = be;
        stallCyc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (dStall[k]) stallCyc++;
            if (dValid[k]) break;
        end
        if (!dValid[k]) chk("d_valid_timeout", k, 32'h0, 32'h1);
        @(posedge clk); #1;
        if (!keep) dReq[k] = 1'b0;
    endtask

    task automatic checkZero(input int k);
        chk("zero_if_valid", k, 32'(ifValid[k]), 32'h0);
        chk("zero_if_rdata", k, ifRdata[k], 32'h0);
        chk("zero_if_stall", k, 32'(ifStall[k]), 32'h0);
        chk("zero_d_valid", k, 32'(dValid[k]), 32'h0);
        chk("zero_d_rdata", k, dRdata[k], 32'h0);
        chk("zero_mem_req", k, 32'(memReq[k]), 32'h0);
        chk("zero_mem_we", k, 32'(memWe[k]), 32'h0);
        chk("zero_mem_addr", k, memAddr[k], 32'h0);
        chk("zero_mem_wdata", k, memWdata[k], 32'h0);
        chk("zero_mem_be", k, 32'(memBe[k]), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int s1;
        int t0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ifReq[k] = 1'b0; ifAddr[k] = '0;
            dReq[k] = 1'b0; dWe[k] = 1'b0; dAddr[k] = '0; dWdata[k] = '0; dBe[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkZero(0);
        checkZero(1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single fetch.
        t0 = cyc;
        pushMem(0, t0 + 1, 1'b0, 32'h40, 32'h0, 4'hF);
        pushRsp(0, 0, t0 + 4, 32'h24020005);
        fetchOp(0, 32'h40, 1'b0, s0);
        chk("single_if_stall_cycles", 0, s0, 4);
        @(negedge clk);
        chk("if_rdata_hold", 0, ifRdata[0], 32'h24020005);
        @(posedge clk); #1;

        // Simultaneous store and fetch: data wins the tie.
        t0 = cyc;
        pushMem(0, t0 + 1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        pushRsp(1, 0, t0 + 4, 32'h0);
        pushMem(0, t0 + 4, 1'b0, 32'h44, 32'h0, 4'hF);
        pushRsp(0, 0, t0 + 7, memWord(32'h44));
        fork
            dataOp(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, s0);
            fetchOp(0, 32'h44, 1'b0, s1);
        join
        chk("simul_d_stall_cycles", 0, s0, 4);
        chk("simul_if_stall_cycles", 0, s1, 7);
        repeat (2) begin @(posedge clk); #1; end

        // Continuous data stream and held fetch: owners D, I, D, I.
        t0 = cyc;
        pushMem(0, t0 + 1, 1'b0, 32'h180, 32'h0, 4'hF);
        pushRsp(1, 0, t0 + 4, memWord(32'h180));
        pushMem(0, t0 + 4, 1'b0, 32'h80, 32'h0, 4'hF);
        pushRsp(0, 0, t0 + 7, memWord(32'h80));
        pushMem(0, t0 + 7, 1'b1, 32'h184, 32'h11223344, 4'h3);
        pushRsp(1, 0, t0 + 10, 32'h0);
        pushMem(0, t0 + 10, 1'b0, 32'h84, 32'h0, 4'hF);
        pushRsp(0, 0, t0 + 13, memWord(32'h84));
        fork
            begin
                dataOp(0, 1'b0, 32'h180, 32'h0, 4'hF, 1'b1, s0);
                dataOp(0, 1'b1, 32'h184, 32'h11223344, 4'h3, 1'b0, s0);
            end
            begin
                fetchOp(0, 32'h80, 1'b1, s1);
                fetchOp(0, 32'h84, 1'b0, s1);
            end
        join
        repeat (2) begin @(posedge clk); #1; end

        // Lone load; d_req is still up in its valid cycle but must not reissue.
        t0 = cyc;
        pushMem(0, t0 + 1, 1'b0, 32'h200, 32'h0, 4'hF);
        pushRsp(1, 0, t0 + 4, memWord(32'h200));
        dataOp(0, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, s0);
        @(negedge clk);
        chk("masked_no_reissue", 0, 32'(memReq[0]), 32'h0);
        @(posedge clk); #1;

        // Last completion was data, so fetch wins the next tie.
        t0 = cyc;
        pushMem(0, t0 + 1, 1'b0, 32'h48, 32'h0, 4'hF);
        pushRsp(0, 0, t0 + 4, memWord(32'h48));
        pushMem(0, t0 + 4, 1'b0, 32'h204, 32'h0, 4'hF);
        pushRsp(1, 0, t0 + 7, memWord(32'h204));
        fork
            fetchOp(0, 32'h48, 1'b0, s1);
            dataOp(0, 1'b0, 32'h204, 32'h0, 4'hF, 1'b0, s0);
        join
        repeat (2) begin @(posedge clk); #1; end

        // Reset in cycle 2 of a load: response dropped, held d_req re-served.
        t0 = cyc;
        pushMem(0, t0 + 1, 1'b0, 32'h300, 32'h0, 4'hF);
        pushMem(0, t0 + 4, 1'b0, 32'h300, 32'h0, 4'hF);
        pushRsp(1, 0, t0 + 7, memWord(32'h300));
        fork
            dataOp(0, 1'b0, 32'h300, 32'h0, 4'hF, 1'b0, s0);
            begin
                repeat (2) begin @(posedge clk); #1; end
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                checkZero(0);
            end
        join
        repeat (2) begin @(posedge clk); #1; end

        // MEM_LAT=1 instance: load, then a fetch issued back-to-back.
        t0 = cyc;
        pushMem(1, t0 + 1, 1'b0, 32'h500, 32'h0, 4'hF);
        pushRsp(1, 1, t0 + 3, memWord(32'h500));
        pushMem(1, t0 + 3, 1'b0, 32'h600, 32'h0, 4'hF);
        pushRsp(0, 1, t0 + 5, memWord(32'h600));
        fork
            dataOp(1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, s0);
            begin
                @(posedge clk); #1;
                fetchOp(1, 32'h600, 1'b0, s1);
            end
        join
        chk("lat1_d_stall_cycles", 1, s0, 3);
        chk("lat1_if_stall_cycles", 1, s1, 4);

        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("scoreboard_drained", 0, memQ.size() + ifQ.size() + dQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
